// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding,
// default datapath width and the fill bit used for a timed-out load.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;

  // A timed-out load returns all ones, replicated to the datapath width.
  localparam logic LOAD_ERR_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles and flags expiry on the TIMEOUT-th cycle so the
// stage can abandon a request that memory never acknowledges.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter holds the number of completed ACCESS cycles, so the last one is TIMEOUT-1.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack handshake and stalls the pipe
// until done. Optional abort-on-timeout is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_MEM,
  input  logic              memRead_MEM,
  input  logic              memWrite_MEM,
  input  logic [DATA_W-1:0] aluResult_MEM,
  input  logic [DATA_W-1:0] storeData_MEM,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData,
  output logic [DATA_W-1:0] loadData,
  output logic              stall,
  output logic              changeEnable,
  output logic              memError
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              mem_op;
  logic              acc_start;
  logic              expired;

  assign mem_op = valid_MEM & (memRead_MEM | memWrite_MEM);

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clr     (acc_start),
    .en      (state_q == ACCESS),
    .expired (expired)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == ACCESS && !memAck && expired) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign memError = err_q;
`else
  assign expired  = 1'b0;
  assign memError = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_d      = ld_q;
    stall     = 1'b0;
    acc_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          acc_start = 1'b1;
          state_d   = ACCESS;
          req_d     = 1'b1;
          // Read+write together is resolved as a store.
          we_d      = memWrite_MEM;
          addr_d    = aluResult_MEM[ADDR_W-1:0];
          wdata_d   = storeData_MEM;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // An ack on the expiry edge is a normal completion.
        if (memAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) ld_d = memRData;
        end else if (expired) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) ld_d = {DATA_W{LOAD_ERR_FILL}};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end

  assign memReq       = req_q;
  assign memWe        = we_q;
  assign memAddr      = addr_q;
  assign memWData     = wdata_q;
  assign loadData     = ld_q;
  assign changeEnable = ~stall;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle vector table plus hand
// sequences for async reset mid-access and long/timed-out accesses.
module tb_mem_access_stage;

  logic        clock, reset;
  logic        valid_MEM, memRead_MEM, memWrite_MEM;
  logic [15:0] aluResult_MEM, storeData_MEM;
  logic        memReq, memWe;
  logic [15:0] memAddr, memWData;
  logic        memAck;
  logic [15:0] memRData, loadData;
  logic        stall, changeEnable, memError;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .valid_MEM     (valid_MEM),
    .memRead_MEM   (memRead_MEM),
    .memWrite_MEM  (memWrite_MEM),
    .aluResult_MEM (aluResult_MEM),
    .storeData_MEM (storeData_MEM),
    .memReq        (memReq),
    .memWe         (memWe),
    .memAddr       (memAddr),
    .memWData      (memWData),
    .memAck        (memAck),
    .memRData      (memRData),
    .loadData      (loadData),
    .stall         (stall),
    .changeEnable  (changeEnable),
    .memError      (memError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v, rd, wr, ack;
    logic [15:0] alu, sd, rdata;
    logic        stall, req, we;
    logic [15:0] addr, wdata, ld;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, rd, wr, ack, input logic [15:0] alu, sd, rdata);
    @(negedge clock);
    valid_MEM = v; memRead_MEM = rd; memWrite_MEM = wr; memAck = ack;
    aluResult_MEM = alu; storeData_MEM = sd; memRData = rdata;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    valid_MEM = 0; memRead_MEM = 0; memWrite_MEM = 0; memAck = 0;
    aluResult_MEM = 0; storeData_MEM = 0; memRData = 0;

    //           v  rd wr ack alu      sd       rdata     st rq we addr     wdata    ld
    tbl[0]  = '{1, 0, 0, 0, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 0, 0, 0, 16'h0007, 16'h9999, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{1, 1, 0, 0, 16'h0042, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[3]  = '{1, 1, 0, 0, 16'h0042, 16'h0000, 16'h0000, 1, 1, 0, 16'h0042, 16'h0000, 16'h0000};
    tbl[4]  = '{1, 1, 0, 1, 16'h0042, 16'h0000, 16'hBEEF, 1, 1, 0, 16'h0042, 16'h0000, 16'h0000};
    tbl[5]  = '{1, 1, 0, 0, 16'h0042, 16'h0000, 16'h0000, 0, 0, 0, 16'h0042, 16'h0000, 16'hBEEF};
    tbl[6]  = '{1, 0, 1, 0, 16'h0010, 16'h1234, 16'h0000, 1, 0, 0, 16'h0042, 16'h0000, 16'hBEEF};
    tbl[7]  = '{1, 0, 1, 1, 16'h0010, 16'h1234, 16'hDEAD, 1, 1, 1, 16'h0010, 16'h1234, 16'hBEEF};
    tbl[8]  = '{1, 0, 1, 0, 16'h0010, 16'h1234, 16'h0000, 0, 0, 1, 16'h0010, 16'h1234, 16'hBEEF};
    tbl[9]  = '{1, 0, 0, 1, 16'h0003, 16'h0000, 16'h7777, 0, 0, 1, 16'h0010, 16'h1234, 16'hBEEF};
    tbl[10] = '{1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 1, 0, 1, 16'h0010, 16'h1234, 16'hBEEF};
    tbl[11] = '{1, 1, 0, 1, 16'h0100, 16'h0000, 16'h1111, 1, 1, 0, 16'h0100, 16'h0000, 16'hBEEF};
    tbl[12] = '{1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0, 16'h0100, 16'h0000, 16'h1111};
    tbl[13] = '{1, 1, 0, 0, 16'h0102, 16'h0000, 16'h0000, 1, 0, 0, 16'h0100, 16'h0000, 16'h1111};
    tbl[14] = '{1, 1, 0, 1, 16'h0102, 16'h0000, 16'h2222, 1, 1, 0, 16'h0102, 16'h0000, 16'h1111};
    tbl[15] = '{1, 1, 0, 0, 16'h0102, 16'h0000, 16'h0000, 0, 0, 0, 16'h0102, 16'h0000, 16'h2222};
    tbl[16] = '{0, 1, 0, 0, 16'h0500, 16'h0000, 16'h0000, 0, 0, 0, 16'h0102, 16'h0000, 16'h2222};
    tbl[17] = '{1, 1, 1, 0, 16'h0200, 16'hAAAA, 16'h0000, 1, 0, 0, 16'h0102, 16'h0000, 16'h2222};
    tbl[18] = '{1, 1, 1, 1, 16'h0200, 16'hAAAA, 16'h5555, 1, 1, 1, 16'h0200, 16'hAAAA, 16'h2222};
    tbl[19] = '{1, 1, 1, 0, 16'h0200, 16'hAAAA, 16'h0000, 0, 0, 1, 16'h0200, 16'hAAAA, 16'h2222};

    // Reset state, and stall following the inputs while held in reset.
    repeat (2) @(negedge clock);
    #1;
    chk("reset_state", {32'd0, stall, changeEnable, memReq, memWe, memError, memAddr, memWData[10:0]},
        {32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h000});
    chk("reset_ldata", {48'd0, loadData}, 64'd0);
    valid_MEM = 1; memRead_MEM = 1;
    #1;
    chk("reset_stall_op", {63'd0, stall}, 64'd1);
    valid_MEM = 0; memRead_MEM = 0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].ack, tbl[i].alu, tbl[i].sd, tbl[i].rdata);
      chk($sformatf("vec%0d", i),
          {10'd0, stall, changeEnable, memReq, memWe, memAddr, memWData, loadData, memError},
          {10'd0, tbl[i].stall, ~tbl[i].stall, tbl[i].req, tbl[i].we, tbl[i].addr,
           tbl[i].wdata, tbl[i].ld, 1'b0});
    end

    // Async reset in the middle of an access.
    drive(1, 1, 0, 0, 16'h0400, 16'h0000, 16'h0000);
    drive(1, 1, 0, 0, 16'h0400, 16'h0000, 16'h0000);
    chk("pre_rst_req", {63'd0, memReq}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_req", {63'd0, memReq}, 64'd0);
    chk("rst_async_regs", {16'd0, memAddr, loadData, 15'd0, stall}, {16'd0, 16'h0000, 16'h0000, 15'd0, 1'b1});
    drive(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h3333);
    reset = 1'b1;
    #1;
    chk("rst_idle_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h3333);
      chk($sformatf("post_rst_ack%0d", i), {46'd0, memReq, stall, loadData}, 64'd0);
    end

    // Load with no ack: abort after 4 ACCESS cycles, or keep waiting.
    drive(1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000);
    chk("to_idle", {62'd0, stall, memReq}, {62'd0, 1'b1, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000);
      chk($sformatf("to_access%0d", k), {61'd0, stall, memReq, memError}, {61'd0, 1'b1, 1'b1, 1'b0});
    end
    drive(1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000);
`ifdef MEM_TIMEOUT_EN
    chk("to_done", {45'd0, stall, memReq, memError, loadData}, {45'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF});
    drive(1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000);
    chk("to_err_sticky0", {62'd0, stall, memError}, {62'd0, 1'b0, 1'b1});
    drive(1, 1, 0, 0, 16'h0302, 16'h0000, 16'h0000);
    drive(1, 1, 0, 1, 16'h0302, 16'h0000, 16'h4321);
    chk("to_retry_req", {63'd0, memReq}, 64'd1);
    drive(1, 1, 0, 0, 16'h0302, 16'h0000, 16'h0000);
    chk("to_retry_done", {45'd0, stall, memReq, memError, loadData}, {45'd0, 1'b0, 1'b0, 1'b1, 16'h4321});
`else
    chk("wait_access5", {62'd0, stall, memReq}, {62'd0, 1'b1, 1'b1});
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000);
      chk($sformatf("wait_hold%0d", k), {62'd0, memReq, memError}, {62'd0, 1'b1, 1'b0});
    end
    drive(1, 1, 0, 1, 16'h0300, 16'h0000, 16'h4321);
    chk("wait_ack_req", {63'd0, memReq}, 64'd1);
    drive(1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000);
    chk("wait_done", {45'd0, stall, memReq, memError, loadData}, {45'd0, 1'b0, 1'b0, 1'b0, 16'h4321});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
